ofm_fifo_to_ram: RTL and testbench

//  Drains one output-feature-map tile from the output FIFO into on-chip RAM.
//  out_fm[M][R][C] is stored row-major; tile (Tm x Tr x Tc) starts at (tile_base_m, tile_base_r, tile_base_c).

---
 rtl/ofm_fifo_to_ram_if.sv | 31 +++
 rtl/ofm_fifo_to_ram.sv | 143 ++++++++++++++
 tb/tb_ofm_fifo_to_ram.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_fifo_to_ram_if.sv
// FIFO read side and RAM write side of the OFM tile drain.
// The drain engine holds the master modport; the FIFO/RAM side holds slave.
interface ofm_fifo_to_ram_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          fifo_pop;
  logic          fifo_empty;
  logic [DW-1:0] data_from_fifo;
  logic          ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_to_ram;

  modport master (
    output fifo_pop,
    input  fifo_empty,
    input  data_from_fifo,
    output ram_wena,
    output ram_addr,
    output data_to_ram
  );

  modport slave (
    input  fifo_pop,
    output fifo_empty,
    output data_from_fifo,
    input  ram_wena,
    input  ram_addr,
    input  data_to_ram
  );
endinterface

// File: rtl/ofm_fifo_to_ram.sv
// Drains one padded output-feature-map tile from the output FIFO into out_fm RAM,
// dropping words whose (m, r, c) position falls outside the feature map.
//
// state | meaning
// IDLE  | waiting for start
// XFER  | popping one word per non-empty cycle, tc -> tr -> tm order
// DRAIN | last write on the RAM port
// DONE  | done pulse, start ignored
module ofm_fifo_to_ram #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int M  = 32,
  parameter int R  = 16,
  parameter int C  = 16,
  parameter int Tm = 8,
  parameter int Tr = 4,
  parameter int Tc = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  input  logic [AW-1:0] tile_base_m,
  input  logic [AW-1:0] tile_base_r,
  input  logic [AW-1:0] tile_base_c,
  ofm_fifo_to_ram_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] PLANE  = AW'(R * C);
  localparam logic [AW-1:0] ROWLEN = AW'(C);
  localparam logic [AW-1:0] M_LIM  = AW'(M);
  localparam logic [AW-1:0] R_LIM  = AW'(R);
  localparam logic [AW-1:0] C_LIM  = AW'(C);
  localparam logic [AW-1:0] TC_MAX = AW'(Tc - 1);
  localparam logic [AW-1:0] TR_MAX = AW'(Tr - 1);
  localparam logic [AW-1:0] TM_MAX = AW'(Tm - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] tc_q, tc_d;
  logic [AW-1:0] tr_q, tr_d;
  logic [AW-1:0] tm_q, tm_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_wena_q, ram_wena_d;

  logic          pop;
  logic          tc_wrap, tr_wrap, tm_wrap;
  logic          last_pop;
  logic [AW-1:0] ch, row, col;
  logic [AW-1:0] addr;
  logic          legal;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_XFER;
      ST_XFER:  if (last_pop) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pop  = (state_q == ST_XFER) && !bus.fifo_empty;
    done = (state_q == ST_DONE);
  end

  // ---------------- tile counters ----------------
  always_comb begin
    tc_wrap  = (tc_q == TC_MAX);
    tr_wrap  = (tr_q == TR_MAX);
    tm_wrap  = (tm_q == TM_MAX);
    last_pop = pop && tc_wrap && tr_wrap && tm_wrap;

    tc_d = tc_q;
    tr_d = tr_q;
    tm_d = tm_q;
    if (state_q == ST_IDLE && start) begin
      tc_d = '0;
      tr_d = '0;
      tm_d = '0;
    end else if (pop) begin
      tc_d = tc_wrap ? '0 : tc_q + 1'b1;
      if (tc_wrap) begin
        tr_d = tr_wrap ? '0 : tr_q + 1'b1;
        if (tr_wrap) tm_d = tm_wrap ? '0 : tm_q + 1'b1;
      end
    end
  end

  // ---------------- address and bounds ----------------
  // All arithmetic wraps at AW bits; legality is judged on the wrapped coordinates.
  always_comb begin
    ch    = tile_base_m + tm_q;
    row   = tile_base_r + tr_q;
    col   = tile_base_c + tc_q;
    addr  = ch * PLANE + row * ROWLEN + col;
    legal = (ch < M_LIM) && (row < R_LIM) && (col < C_LIM);
  end

  always_comb begin
    ram_wena_d = pop && legal;
    ram_addr_d = pop ? addr : ram_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q       <= '0;
      tr_q       <= '0;
      tm_q       <= '0;
      ram_wena_q <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      tc_q       <= tc_d;
      tr_q       <= tr_d;
      tm_q       <= tm_d;
      ram_wena_q <= ram_wena_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // FIFO data arrives the cycle after the pop, aligned with the registered address.
  assign bus.fifo_pop    = pop;
  assign bus.ram_wena    = ram_wena_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.data_to_ram = bus.data_from_fifo;

endmodule

// File: tb/tb_ofm_fifo_to_ram.sv
// Directed bench for ofm_fifo_to_ram with a 4x4x4 feature map and 2x2x2 tile.
// FIFO data is the global pop ordinal, so every write's data identifies its pop.
module tb_ofm_fifo_to_ram;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic [AW-1:0] bm = '0, br = '0, bc = '0;

  ofm_fifo_to_ram_if #(.AW(AW), .DW(DW)) bus ();

  ofm_fifo_to_ram #(
    .AW(AW), .DW(DW), .M(4), .R(4), .C(4), .Tm(2), .Tr(2), .Tc(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .tile_base_m (bm),
    .tile_base_r (br),
    .tile_base_c (bc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ncyc = 0, pop_n = 0, wr_n = 0, done_n = 0;
  int tile_p0 = 0;
  int pop_cyc [256];
  int wr_cyc  [256];
  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];
  int done_cyc [16];
  logic pop_seen = 1'b0;
  logic [DW-1:0] widx = '0;

  always @(negedge clk) begin
    ncyc++;
    if (bus.fifo_pop) begin
      if (pop_n < 256) pop_cyc[pop_n] = ncyc;
      pop_n++;
    end
    if (bus.ram_wena) begin
      if (wr_n < 256) begin
        wr_cyc[wr_n]  = ncyc;
        wr_addr[wr_n] = bus.ram_addr;
        wr_data[wr_n] = bus.data_to_ram;
      end
      wr_n++;
    end
    if (done) begin
      if (done_n < 16) done_cyc[done_n] = ncyc;
      done_n++;
    end
    pop_seen = bus.fifo_pop;
  end

  always @(posedge clk) begin
    if (pop_seen) begin
      bus.data_from_fifo <= widx;
      widx <= widx + 1'b1;
    end
  end

  task automatic start_tile(input logic [31:0] m, input logic [31:0] r, input logic [31:0] c);
    tile_p0 = pop_n;
    bm = m; br = r; bc = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int stall_after, input int stall_len,
                                input int restart_at, input string name);
    int d0;
    int left;
    bit ok;
    d0 = done_n;
    left = stall_len;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (left > 0 && (pop_n - tile_p0) == stall_after) begin
        bus.fifo_empty = 1'b1;
        left--;
      end else begin
        bus.fifo_empty = 1'b0;
      end
      start = (i == restart_at);
      @(posedge clk); #1;
      if (done_n > d0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    bus.fifo_empty = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0", bus.fifo_pop); end
    total++; if (bus.ram_wena !== 1'b0) begin bad++; $display("FAIL reset_wena: got %b want 0", bus.ram_wena); end
    total++; if (bus.ram_addr !== 32'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int exp_a [8] = '{0, 1, 4, 5, 16, 17, 20, 21};
    int w0, d0, p0;
    w0 = wr_n; d0 = done_n;
    start_tile(0, 0, 0);
    p0 = tile_p0;
    run_until_done(-1, 0, -1, "basic");
    idle(3);
    total++; if (pop_n - p0 != 8) begin bad++; $display("FAIL basic_pops: got %0d want 8", pop_n - p0); end
    total++; if (wr_n - w0 != 8) begin bad++; $display("FAIL basic_writes: got %0d want 8", wr_n - w0); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_n - d0); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (wr_addr[w0+k] !== 32'(exp_a[k])) begin
        bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", k, wr_addr[w0+k], exp_a[k]);
      end
      total++;
      if (wr_data[w0+k] !== 32'(p0 + k)) begin
        bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", k, wr_data[w0+k], p0 + k);
      end
      total++;
      if (wr_cyc[w0+k] != pop_cyc[p0+k] + 1) begin
        bad++; $display("FAIL basic_latency[%0d]: write cycle %0d want %0d", k, wr_cyc[w0+k], pop_cyc[p0+k] + 1);
      end
      total++;
      if (wr_cyc[w0+k] != wr_cyc[w0] + k) begin
        bad++; $display("FAIL basic_consec[%0d]: write cycle %0d want %0d", k, wr_cyc[w0+k], wr_cyc[w0] + k);
      end
    end
    total++;
    if (done_cyc[d0] != pop_cyc[p0+7] + 2) begin
      bad++; $display("FAIL basic_done_time: done cycle %0d want %0d", done_cyc[d0], pop_cyc[p0+7] + 2);
    end
  endtask

  task automatic test_clip();
    int w0, d0, p0;
    w0 = wr_n; d0 = done_n;
    start_tile(0, 3, 3);
    p0 = tile_p0;
    run_until_done(-1, 0, -1, "clip");
    idle(3);
    total++; if (pop_n - p0 != 8) begin bad++; $display("FAIL clip_pops: got %0d want 8", pop_n - p0); end
    total++; if (wr_n - w0 != 2) begin bad++; $display("FAIL clip_writes: got %0d want 2", wr_n - w0); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL clip_done_cnt: got %0d want 1", done_n - d0); end
    total++; if (wr_addr[w0] !== 32'd15) begin bad++; $display("FAIL clip_addr0: got %0d want 15", wr_addr[w0]); end
    total++; if (wr_data[w0] !== 32'(p0)) begin bad++; $display("FAIL clip_data0: got %0d want %0d", wr_data[w0], p0); end
    total++; if (wr_addr[w0+1] !== 32'd31) begin bad++; $display("FAIL clip_addr1: got %0d want 31", wr_addr[w0+1]); end
    total++; if (wr_data[w0+1] !== 32'(p0 + 4)) begin bad++; $display("FAIL clip_data1: got %0d want %0d", wr_data[w0+1], p0 + 4); end
  endtask

  task automatic test_stall();
    int exp_a [8] = '{0, 1, 4, 5, 16, 17, 20, 21};
    int w0, d0, p0;
    w0 = wr_n; d0 = done_n;
    start_tile(0, 0, 0);
    p0 = tile_p0;
    run_until_done(2, 3, -1, "stall");
    idle(3);
    total++; if (pop_n - p0 != 8) begin bad++; $display("FAIL stall_pops: got %0d want 8", pop_n - p0); end
    total++; if (wr_n - w0 != 8) begin bad++; $display("FAIL stall_writes: got %0d want 8", wr_n - w0); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL stall_done_cnt: got %0d want 1", done_n - d0); end
    total++;
    if (pop_cyc[p0+2] - pop_cyc[p0+1] != 4) begin
      bad++; $display("FAIL stall_pop_gap: got %0d want 4", pop_cyc[p0+2] - pop_cyc[p0+1]);
    end
    total++;
    if (wr_cyc[w0+2] - wr_cyc[w0+1] != 4) begin
      bad++; $display("FAIL stall_wr_gap: got %0d want 4", wr_cyc[w0+2] - wr_cyc[w0+1]);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (wr_addr[w0+k] !== 32'(exp_a[k]) || wr_data[w0+k] !== 32'(p0 + k)) begin
        bad++;
        $display("FAIL stall_word[%0d]: got addr %0d data %0d want addr %0d data %0d",
                 k, wr_addr[w0+k], wr_data[w0+k], exp_a[k], p0 + k);
      end
    end
  endtask

  task automatic test_restart();
    int w0, d0, p0;
    w0 = wr_n; d0 = done_n;
    start_tile(0, 0, 0);
    p0 = tile_p0;
    run_until_done(-1, 0, 2, "restart");
    idle(6);
    total++; if (pop_n - p0 != 8) begin bad++; $display("FAIL restart_pops: got %0d want 8", pop_n - p0); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL restart_done_cnt: got %0d want 1", done_n - d0); end
    total++; if (wr_n - w0 != 8) begin bad++; $display("FAIL restart_writes: got %0d want 8", wr_n - w0); end
  endtask

  task automatic test_abort();
    int d0, p0, w1;
    bit hit;
    d0 = done_n;
    start_tile(0, 0, 0);
    p0 = tile_p0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pop_n - p0 == 4) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach4: pops %0d want 4", pop_n - p0); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL abort_pop: got %b want 0", bus.fifo_pop); end
    total++; if (bus.ram_wena !== 1'b0) begin bad++; $display("FAIL abort_wena: got %b want 0", bus.ram_wena); end
    total++; if (bus.ram_addr !== 32'd0) begin bad++; $display("FAIL abort_addr: got %0d want 0", bus.ram_addr); end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(5);
    total++; if (done_n != d0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_n - d0); end
    total++; if (pop_n - p0 != 4) begin bad++; $display("FAIL abort_pops: got %0d want 4", pop_n - p0); end
    w1 = wr_n;
    start_tile(0, 0, 0);
    p0 = tile_p0;
    run_until_done(-1, 0, -1, "abort_retry");
    idle(3);
    total++; if (pop_n - p0 != 8) begin bad++; $display("FAIL abort_retry_pops: got %0d want 8", pop_n - p0); end
    total++; if (wr_n - w1 != 8) begin bad++; $display("FAIL abort_retry_writes: got %0d want 8", wr_n - w1); end
    total++; if (wr_addr[w1] !== 32'd0) begin bad++; $display("FAIL abort_retry_addr0: got %0d want 0", wr_addr[w1]); end
  endtask

  task automatic test_back_to_back();
    int d0, w1;
    d0 = done_n;
    start_tile(0, 0, 0);
    run_until_done(-1, 0, -1, "b2b_first");
    w1 = wr_n;
    start_tile(2, 0, 0);
    run_until_done(-1, 0, -1, "b2b_second");
    idle(3);
    total++; if (done_n - d0 != 2) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 2", done_n - d0); end
    total++; if (wr_n - w1 != 8) begin bad++; $display("FAIL b2b_writes: got %0d want 8", wr_n - w1); end
    total++; if (wr_addr[w1] !== 32'd32) begin bad++; $display("FAIL b2b_first_addr: got %0d want 32", wr_addr[w1]); end
    total++; if (wr_addr[w1+7] !== 32'd53) begin bad++; $display("FAIL b2b_last_addr: got %0d want 53", wr_addr[w1+7]); end
    total++;
    if (done_cyc[d0+1] - done_cyc[d0] != 11) begin
      bad++; $display("FAIL b2b_done_spacing: got %0d want 11", done_cyc[d0+1] - done_cyc[d0]);
    end
  endtask

  initial begin
    bus.fifo_empty = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
